// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard detection for an in-order pipeline.
// An in-order circular table holds the destination registers of long-latency
// operations that have left the memory stage but not yet written back.
// Decode stalls on a source that matches a pending entry. Short-range
// execute/memory hazards are handled by the HAZARD_FORWARDING_EN macro:
//   defined   - forward from execute/memory, and stall only on a load-use
//               match in execute;
//   undefined - no forwarding, and stall on any execute/memory match.
// Handshake: issue_valid/complete_valid are single-cycle strobes with no
// ready return. stall_decode is the only back-pressure. A push into a full
// table without a pop in the same cycle is dropped and sets the sticky
// overflow flag.
module hazard_scoreboard #(
  parameter int DEPTH          = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int COUNTER_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [REG_ADDR_WIDTH-1:0]    rs1_address_decode,
  input  logic [REG_ADDR_WIDTH-1:0]    rs2_address_decode,
  input  logic                         uses_rs1,
  input  logic                         uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]    rd_address_execute,
  input  logic [REG_ADDR_WIDTH-1:0]    rd_address_memory,
  input  logic                         load_execute,
  input  logic                         issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    issue_rd,
  input  logic                         complete_valid,
  input  logic                         flush,
  output logic                         stall_decode,
  output logic [1:0]                   forward_rs1,
  output logic [1:0]                   forward_rs2,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count,
  output logic                         full,
  output logic                         overflow,
  output logic [COUNTER_WIDTH-1:0]     stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

  // Table state
  logic [REG_ADDR_WIDTH-1:0] entry_q [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] entry_d [DEPTH];
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic [COUNTER_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;

  // Decode-side terms
  logic       rs1_live, rs2_live;
  logic       rs1_pending, rs2_pending;
  logic       rs1_ex_match, rs2_ex_match;
  logic       rs1_mem_match, rs2_mem_match;
  logic       stage_stall;
  logic       full_issue_stall;
  logic [1:0] fwd1_raw, fwd2_raw;

  // Table update terms
  logic push_req, pop_req, push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full          = (count_q == DEPTH_CNT);
  assign pending_count = count_q;
  assign overflow      = overflow_q;
  assign stall_cycles  = stall_cycles_q;

  assign rs1_live      = uses_rs1 && (rs1_address_decode != '0);
  assign rs2_live      = uses_rs2 && (rs2_address_decode != '0);
  assign rs1_ex_match  = rs1_live && (rs1_address_decode == rd_address_execute);
  assign rs2_ex_match  = rs2_live && (rs2_address_decode == rd_address_execute);
  assign rs1_mem_match = rs1_live && (rs1_address_decode == rd_address_memory);
  assign rs2_mem_match = rs2_live && (rs2_address_decode == rd_address_memory);

  // Match live sources against every valid entry; an entry retiring this
  // cycle is still valid here, so the dependant waits one more cycle.
  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i] == rs1_address_decode)) rs1_pending = 1'b1;
      if (valid_q[i] && (entry_q[i] == rs2_address_decode)) rs2_pending = 1'b1;
    end
    rs1_pending = rs1_pending && rs1_live;
    rs2_pending = rs2_pending && rs2_live;
  end

`ifdef HAZARD_FORWARDING_EN
  // Forward from execute (priority) or memory; only load-use must stall.
  always_comb begin
    stage_stall = load_execute && (rs1_ex_match || rs2_ex_match);
    fwd1_raw    = rs1_ex_match ? 2'd1 : (rs1_mem_match ? 2'd2 : 2'd0);
    fwd2_raw    = rs2_ex_match ? 2'd1 : (rs2_mem_match ? 2'd2 : 2'd0);
  end
`else
  logic unused_load_execute;
  assign unused_load_execute = load_execute;

  // No bypass network: any in-flight stage producer stalls decode.
  always_comb begin
    stage_stall = rs1_ex_match || rs1_mem_match || rs2_ex_match || rs2_mem_match;
    fwd1_raw    = 2'd0;
    fwd2_raw    = 2'd0;
  end
`endif

  // Stall and forwarding outputs; forwarding is suppressed while stalled.
  always_comb begin
    full_issue_stall = full && issue_valid && !complete_valid;
    stall_decode     = rs1_pending || rs2_pending || stage_stall || full_issue_stall;
    forward_rs1      = stall_decode ? 2'd0 : fwd1_raw;
    forward_rs2      = stall_decode ? 2'd0 : fwd2_raw;
  end

  // Next-state for the circular table, overflow flag and stall counter.
  always_comb begin
    entry_d        = entry_q;
    valid_d        = valid_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    stall_cycles_d = stall_cycles_q;

    push_req = issue_valid && (issue_rd != '0);
    pop_req  = complete_valid && (count_q != '0);
    push_ok  = push_req && (!full || pop_req);

    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_req && full && !pop_req) overflow_d = 1'b1;
      // Pop first so that on a full swap (head == tail) the push wins.
      if (pop_req) begin
        valid_d[head_q] = 1'b0;
        head_d          = ptr_inc(head_q);
      end
      if (push_ok) begin
        entry_d[tail_q] = issue_rd;
        valid_d[tail_q] = 1'b1;
        tail_d          = ptr_inc(tail_q);
      end
      case ({push_ok, pop_req})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (stall_decode && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + COUNTER_WIDTH'(1);
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      valid_q        <= valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
